// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Imported by the arbiter and anything that inspects its state.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_D = 2'd1,
      BUSY_I = 2'd2
   } arb_state_t;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0033;
   localparam logic [3:0]  MEM_BE_FULL = 4'hF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported I/D memory between fetch and the memory stage.
// Data side has priority; a starvation counter forces periodic fetch grants.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT_CYC  = 255,
   parameter int CNT_W        = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   output logic        if_err,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [3:0]  dm_be,
   output logic [31:0] dm_rdata,
   output logic        dm_ready,
   output logic        dm_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stall_if,
   output logic        stall_mem
);

   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT_CYC - 1);

   arb_state_t       state_q;
   arb_state_t       state_d;
   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] wait_cnt;
   logic             fetch_turn;
   logic             grant_d;
   logic             grant_i;
   logic             finish;
   logic             tmo;
   logic             busy;
   logic             is_d;
   logic             is_i;

   assign fetch_turn = if_req && (starve_cnt == STARVE_MAX);
   assign busy       = (state_q == BUSY_D) || (state_q == BUSY_I);
   assign is_d       = (state_q == BUSY_D);
   assign is_i       = (state_q == BUSY_I);

   // Next-state: arbitrate in IDLE, wait for ack or timeout when busy.
   always_comb begin
      state_d = state_q;
      grant_d = 1'b0;
      grant_i = 1'b0;
      finish  = 1'b0;
      tmo     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (dm_req && !fetch_turn) begin
               grant_d = 1'b1;
               state_d = BUSY_D;
            end else if (if_req) begin
               grant_i = 1'b1;
               state_d = BUSY_I;
            end
         end
         BUSY_D, BUSY_I: begin
            if (mem_ack) begin
               finish  = 1'b1;
               state_d = IDLE;
            end else if (wait_cnt == WAIT_LAST) begin
               tmo     = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Memory-side request: latch the winner, hold until ack or abort.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
      end else if (grant_d) begin
         mem_req   <= 1'b1;
         mem_we    <= dm_we;
         mem_addr  <= dm_addr;
         mem_wdata <= dm_wdata;
         mem_be    <= dm_be;
      end else if (grant_i) begin
         mem_req   <= 1'b1;
         mem_we    <= 1'b0;
         mem_addr  <= if_addr;
         mem_wdata <= '0;
         mem_be    <= MEM_BE_FULL;
      end else if (finish || tmo) begin
         mem_req   <= 1'b0;
      end
   end

   // Fetch-side response: one-cycle ready, NOP on abort.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_rdata <= NOP_INSTR;
         if_ready <= 1'b0;
         if_err   <= 1'b0;
      end else begin
         if_ready <= is_i && (finish || tmo);
         if_err   <= is_i && tmo;
         if (is_i && finish) begin
            if_rdata <= mem_rdata;
         end else if (is_i && tmo) begin
            if_rdata <= NOP_INSTR;
         end
      end
   end

   // Data-side response: loads capture data, stores keep old value.
   always_ff @(posedge clk) begin
      if (rst) begin
         dm_rdata <= '0;
         dm_ready <= 1'b0;
         dm_err   <= 1'b0;
      end else begin
         dm_ready <= is_d && (finish || tmo);
         dm_err   <= is_d && tmo;
         if (is_d && finish && !mem_we) begin
            dm_rdata <= mem_rdata;
         end else if (is_d && tmo) begin
            dm_rdata <= '0;
         end
      end
   end

   // Starvation count of data grants taken while fetch was waiting.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (grant_i) begin
         starve_cnt <= '0;
      end else if (grant_d && if_req) begin
         if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end else if ((state_q == IDLE) && !if_req) begin
         starve_cnt <= '0;
      end
   end

   // Busy-cycle counter feeding the timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (grant_d || grant_i) begin
         wait_cnt <= '0;
      end else if (busy && !finish && !tmo) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign stall_if  = if_req && !if_ready;
   assign stall_mem = dm_req && !dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter.
// A transaction-level model predicts every registered output.
module tb_mem_port_arbiter;

   localparam int LIMIT = 4;
   localparam int TMO   = 255;
   localparam logic [31:0] NOP = 32'h0000_0033;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        if_err;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_be;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        dm_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stall_if;
   logic        stall_mem;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .STARVE_LIMIT(LIMIT),
      .TIMEOUT_CYC (TMO),
      .CNT_W       (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_ready (if_ready),
      .if_err   (if_err),
      .dm_req   (dm_req),
      .dm_we    (dm_we),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_be    (dm_be),
      .dm_rdata (dm_rdata),
      .dm_ready (dm_ready),
      .dm_err   (dm_err),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_be   (mem_be),
      .mem_rdata(mem_rdata),
      .mem_ack  (mem_ack),
      .stall_if (stall_if),
      .stall_mem(stall_mem)
   );

   // Reference model: one pending transaction record plus response values.
   typedef struct {
      bit          is_data;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          waited;
   } txn_t;

   bit          pend;
   txn_t        cur;
   int          starve;
   bit          just_rst;
   logic [31:0] e_if_rdata;
   logic [31:0] e_dm_rdata;
   bit          e_if_rdy;
   bit          e_dm_rdy;
   bit          e_if_err;
   bit          e_dm_err;
   int          fetch_grants;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      pend       = 1'b0;
      cur        = '{0, 0, '0, '0, '0, 0};
      starve     = 0;
      just_rst   = 1'b1;
      e_if_rdata = NOP;
      e_dm_rdata = '0;
      e_if_rdy   = 1'b0;
      e_dm_rdy   = 1'b0;
      e_if_err   = 1'b0;
      e_dm_err   = 1'b0;
   endtask

   // Advance the model by one clock using the inputs now applied.
   task automatic model_update();
      bit fetch_first;
      if (rst) begin
         model_reset();
         return;
      end
      just_rst = 1'b0;
      e_if_rdy = 1'b0;
      e_dm_rdy = 1'b0;
      e_if_err = 1'b0;
      e_dm_err = 1'b0;
      if (pend) begin
         if (mem_ack) begin
            pend = 1'b0;
            if (cur.is_data) begin
               e_dm_rdy = 1'b1;
               if (!cur.we) e_dm_rdata = mem_rdata;
            end else begin
               e_if_rdy   = 1'b1;
               e_if_rdata = mem_rdata;
            end
         end else begin
            cur.waited++;
            if (cur.waited == TMO) begin
               pend = 1'b0;
               if (cur.is_data) begin
                  e_dm_rdy   = 1'b1;
                  e_dm_err   = 1'b1;
                  e_dm_rdata = '0;
               end else begin
                  e_if_rdy   = 1'b1;
                  e_if_err   = 1'b1;
                  e_if_rdata = NOP;
               end
            end
         end
      end else begin
         fetch_first = if_req && (starve == LIMIT);
         if (dm_req && !fetch_first) begin
            pend = 1'b1;
            cur  = '{1, dm_we, dm_addr, dm_wdata, dm_be, 0};
            if (if_req) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
            else starve = 0;
         end else if (if_req) begin
            pend = 1'b1;
            cur  = '{0, 0, if_addr, '0, 4'hF, 0};
            starve = 0;
            fetch_grants++;
         end else begin
            starve = 0;
         end
      end
   endtask

   // One clock: inputs are already applied at the negedge.
   task automatic step();
      #1;
      chk("stall_if", 32'(stall_if), 32'(if_req && !e_if_rdy));
      chk("stall_mem", 32'(stall_mem), 32'(dm_req && !e_dm_rdy));
      model_update();
      @(posedge clk);
      @(negedge clk);
      chk("mem_req", 32'(mem_req), 32'(pend));
      if (pend) begin
         chk("mem_we", 32'(mem_we), 32'(cur.we));
         chk("mem_addr", mem_addr, cur.addr);
         chk("mem_be", 32'(mem_be), 32'(cur.be));
         if (cur.is_data && cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
      end
      if (just_rst) begin
         chk("rst_mem_we", 32'(mem_we), 32'd0);
         chk("rst_mem_addr", mem_addr, 32'd0);
         chk("rst_mem_wdata", mem_wdata, 32'd0);
         chk("rst_mem_be", 32'(mem_be), 32'd0);
      end
      chk("if_ready", 32'(if_ready), 32'(e_if_rdy));
      chk("if_err", 32'(if_err), 32'(e_if_err));
      chk("dm_ready", 32'(dm_ready), 32'(e_dm_rdy));
      chk("dm_err", 32'(dm_err), 32'(e_dm_err));
      chk("if_rdata", if_rdata, e_if_rdata);
      chk("dm_rdata", dm_rdata, e_dm_rdata);
   endtask

   task automatic quiet();
      rst      = 1'b0;
      if_req   = 1'b0;
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      mem_ack  = 1'b0;
      if_addr  = $urandom;
      dm_addr  = $urandom;
      dm_wdata = $urandom;
      dm_be    = 4'($urandom);
      mem_rdata = $urandom;
   endtask

   task automatic do_reset();
      quiet();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic rand_inputs();
      rst = ($urandom_range(0, 199) == 0);
      if (!(if_req && !e_if_rdy && $urandom_range(0, 19) != 0))
         if_req = 1'($urandom_range(0, 1));
      if (!(dm_req && !e_dm_rdy && $urandom_range(0, 19) != 0)) begin
         dm_req = 1'($urandom_range(0, 1));
         dm_we  = 1'($urandom_range(0, 1));
      end
      if_addr   = $urandom;
      dm_addr   = $urandom;
      dm_wdata  = $urandom;
      dm_be     = 4'($urandom);
      mem_ack   = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
   endtask

   initial begin
      int fg0;
      model_reset();
      fetch_grants = 0;
      quiet();
      @(negedge clk);
      do_reset();

      // Single fetch, ack in the second busy cycle.
      if_req  = 1'b1;
      if_addr = 32'h1000_0000;
      step();
      step();
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      step();
      mem_ack = 1'b0;
      if_req  = 1'b0;
      step();

      // Store and fetch together: store first, fetch in the ready cycle.
      if_req   = 1'b1;
      if_addr  = 32'h1000_0004;
      dm_req   = 1'b1;
      dm_we    = 1'b1;
      dm_addr  = 32'h2000_0004;
      dm_wdata = 32'hCAFE_F00D;
      dm_be    = 4'b0011;
      step();
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      dm_req  = 1'b0;
      step();
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      if_req  = 1'b0;
      step();

      // Continuous contention: fetch must get the fifth grant.
      fg0    = fetch_grants;
      if_req = 1'b1;
      dm_req = 1'b1;
      dm_we  = 1'b0;
      for (int i = 0; i < 12; i++) begin
         mem_ack   = i[0];
         mem_rdata = $urandom;
         dm_addr   = 32'h3000_0000 + 32'(i);
         step();
      end
      chk("starve_fetch_grants", 32'(fetch_grants - fg0), 32'd1);
      quiet();
      step();

      // Load never acked: abort after the busy-cycle limit.
      dm_req = 1'b1;
      step();
      dm_req = 1'b0;
      for (int i = 0; i < TMO + 2; i++) step();

      // Reset during a fetch, then a stray ack.
      if_req = 1'b1;
      step();
      step();
      rst = 1'b1;
      step();
      rst     = 1'b0;
      if_req  = 1'b0;
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      step();

      // Fetch never acked: abort returns a NOP.
      if_req = 1'b1;
      step();
      if_req = 1'b0;
      for (int i = 0; i < TMO + 2; i++) step();

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
